// File: rtl/grf_pkg.sv
// Shared types and the pending-write counter update rule for the GRF scoreboard.
package grf_pkg;

  localparam int CNT_W = 2;
  typedef logic [CNT_W-1:0] grf_cnt_t;
  localparam grf_cnt_t CNT_MAX = 2'd3;

  // Simultaneous inc and dec cancel; the counter never wraps in either direction.
  function automatic grf_cnt_t pend_next(input logic inc, input logic dec, input grf_cnt_t cur);
    grf_cnt_t nxt;
    nxt = cur;
    if (inc && !dec && cur != CNT_MAX) nxt = cur + 1'b1;
    if (dec && !inc && cur != '0)      nxt = cur - 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/grf_sb_if.sv
// Decode-stage port bundle of the register file: write/retire, read ports and issue handshake.
// Issue handshake: a producer is accepted on a rising edge where iss_valid && iss_ready;
// upstream holds iss_valid/iss_addr until then.
interface grf_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NR     = 2
);
  logic                 we;
  logic [ADDR_W-1:0]    wa;
  logic [DATA_W-1:0]    wd;
  logic [31:0]          wpc;
  logic                 wb_clr;
  logic [NR*ADDR_W-1:0] ra;
  logic [NR*DATA_W-1:0] rd;
  logic [NR-1:0]        hazard;
  logic                 iss_valid;
  logic [ADDR_W-1:0]    iss_addr;
  logic                 iss_ready;

  modport master (
    output we, wa, wd, wpc, wb_clr, ra, iss_valid, iss_addr,
    input  rd, hazard, iss_ready
  );

  modport slave (
    input  we, wa, wd, wpc, wb_clr, ra, iss_valid, iss_addr,
    output rd, hazard, iss_ready
  );
endinterface

// File: rtl/grf_pend_cnt.sv
// One saturating pending-write counter; one instance per non-zero register.
module grf_pend_cnt
  import grf_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     inc,
  input  logic     dec,
  output grf_cnt_t cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= pend_next(inc, dec, cnt);
  end

endmodule

// File: rtl/grf_sb.sv
// General register file with NR bypassed read ports and a per-register pending-write scoreboard.
// Optional write trace enabled by defining GRF_WRITE_TRACE_EN.
module grf_sb
  import grf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NR     = 2
) (
  input  logic      clk,
  input  logic      reset,
  grf_sb_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       regs [DEPTH];
  grf_cnt_t [DEPTH-1:0]    pend;
  logic [DEPTH-1:0]        inc_vec;
  logic [DEPTH-1:0]        dec_vec;
  logic                    iss_ready_w;
  logic [ADDR_W-1:0]       ra_k;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (bus.we && bus.wa != '0) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  always_comb begin
    dec_vec = '0;
    if (bus.we && bus.wb_clr && bus.wa != '0) dec_vec[bus.wa] = 1'b1;
  end

  // A retiring writeback frees a slot in the same cycle, so a full counter may still accept.
  assign iss_ready_w   = (pend[bus.iss_addr] != CNT_MAX) || dec_vec[bus.iss_addr];
  assign bus.iss_ready = iss_ready_w;

  always_comb begin
    inc_vec = '0;
    if (bus.iss_valid && iss_ready_w && bus.iss_addr != '0) inc_vec[bus.iss_addr] = 1'b1;
  end

  assign pend[0] = '0;
  for (genvar a = 1; a < DEPTH; a++) begin : g_pend
    grf_pend_cnt u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_vec[a]),
      .dec   (dec_vec[a]),
      .cnt   (pend[a])
    );
  end

  // Hazard clears when the last outstanding producer writes back this cycle (pend - dec == 0).
  always_comb begin
    bus.rd     = '0;
    bus.hazard = '0;
    ra_k       = '0;
    for (int k = 0; k < NR; k++) begin
      ra_k = bus.ra[k*ADDR_W +: ADDR_W];
      if (bus.we && bus.wa == ra_k && ra_k != '0)
        bus.rd[k*DATA_W +: DATA_W] = bus.wd;
      else if (ra_k != '0)
        bus.rd[k*DATA_W +: DATA_W] = regs[ra_k];
      bus.hazard[k] = (ra_k != '0) && (pend[ra_k] != grf_cnt_t'(dec_vec[ra_k]));
    end
  end

`ifdef GRF_WRITE_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && bus.we && bus.wa != '0)
      $display("%0t@%08h: $%d <= %08h", $time, bus.wpc, bus.wa, bus.wd);
  end
`else
  logic unused_wpc;
  assign unused_wpc = ^bus.wpc;
`endif

endmodule

// File: tb/tb_grf_sb.sv
// Self-checking bench for grf_sb: directed scenarios then random traffic against a behavioural model.
module tb_grf_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NR     = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic reset;

  grf_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR)) bus ();

  grf_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Behavioural model: architectural register values and outstanding-producer counts.
  logic [DATA_W-1:0] m_reg  [DEPTH];
  int                m_pend [DEPTH];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] ra_of(input int k);
    return bus.ra[k*ADDR_W +: ADDR_W];
  endfunction

  task automatic set_ra(input int k, input logic [ADDR_W-1:0] v);
    bus.ra[k*ADDR_W +: ADDR_W] = v;
  endtask

  function automatic bit retiring(input int a);
    return bus.we && bus.wb_clr && int'(bus.wa) == a && a != 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    if (bus.we && int'(bus.wa) == a) return bus.wd;
    return m_reg[a];
  endfunction

  function automatic logic exp_hazard(input int a);
    int outstanding;
    outstanding = m_pend[a] - (retiring(a) ? 1 : 0);
    return (a != 0) && (outstanding != 0);
  endfunction

  function automatic logic exp_ready();
    int a;
    a = int'(bus.iss_addr);
    return (m_pend[a] < 3) || retiring(a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 0;
    end
  endtask

  // Called just after a rising edge while inputs still hold their pre-edge values.
  task automatic model_edge(input logic ready_before);
    int ia;
    int wa;
    bit issued;
    bit retired;
    if (!reset) begin
      model_clear();
      return;
    end
    ia      = int'(bus.iss_addr);
    wa      = int'(bus.wa);
    issued  = bus.iss_valid && ready_before && ia != 0;
    retired = bus.we && bus.wb_clr && wa != 0;
    if (bus.we && wa != 0) m_reg[wa] = bus.wd;
    if (issued && retired && ia == wa) return;
    if (issued && m_pend[ia] < 3) m_pend[ia]++;
    if (retired && m_pend[wa] > 0) m_pend[wa]--;
  endtask

  task automatic check_all();
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rd%0d", k), bus.rd[k*DATA_W +: DATA_W], exp_rd(int'(ra_of(k))));
      chk($sformatf("hazard%0d", k), {31'd0, bus.hazard[k]}, {31'd0, exp_hazard(int'(ra_of(k)))});
    end
    chk("iss_ready", {31'd0, bus.iss_ready}, {31'd0, exp_ready()});
  endtask

  // Inputs must already be driven; checks between edges, then advances one clock.
  task automatic step();
    logic rdy;
    #1;
    check_all();
    rdy = exp_ready();
    @(posedge clk);
    model_edge(rdy);
    #1;
  endtask

  task automatic idle();
    bus.we        = 1'b0;
    bus.wa        = '0;
    bus.wd        = '0;
    bus.wpc       = '0;
    bus.wb_clr    = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_addr  = '0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    model_clear();
    idle();
    bus.ra = '0;
    reset  = 1'b0;
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    // Write with same-cycle bypass, then plain read.
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hDEADBEEF; set_ra(0, 5'd3);
    #1;
    chk("bypass_rd0", bus.rd[0 +: DATA_W], 32'hDEADBEEF);
    step();
    idle();
    #1;
    chk("stored_rd0", bus.rd[0 +: DATA_W], 32'hDEADBEEF);
    step();

    // Register 0 is immutable and never scoreboarded.
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF; set_ra(0, 5'd0); set_ra(1, 5'd0);
    step();
    idle();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
    step();
    step();
    bus.iss_valid = 1'b0;
    #1;
    chk("r0_rd", bus.rd[0 +: DATA_W], 32'h0);
    chk("r0_hazard", {31'd0, bus.hazard[0]}, 32'd0);
    chk("r0_ready", {31'd0, bus.iss_ready}, 32'd1);
    step();

    // Scoreboard raise at issue, clear and bypass at writeback.
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7; set_ra(0, 5'd7);
    #1;
    chk("iss_same_cycle_hazard", {31'd0, bus.hazard[0]}, 32'd0);
    step();
    idle();
    #1;
    chk("sb_hazard_set", {31'd0, bus.hazard[0]}, 32'd1);
    step();
    bus.we = 1'b1; bus.wa = 5'd7; bus.wb_clr = 1'b1; bus.wd = 32'h42;
    #1;
    chk("sb_hazard_clr", {31'd0, bus.hazard[0]}, 32'd0);
    chk("sb_bypass", bus.rd[0 +: DATA_W], 32'h42);
    step();
    idle();

    // Saturation at three outstanding producers.
    set_ra(1, 5'd9);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
    repeat (3) step();
    #1;
    chk("sat_not_ready", {31'd0, bus.iss_ready}, 32'd0);
    step();
    bus.we = 1'b1; bus.wa = 5'd9; bus.wb_clr = 1'b1; bus.wd = 32'h99;
    #1;
    chk("sat_ready_on_dec", {31'd0, bus.iss_ready}, 32'd1);
    step();
    bus.iss_valid = 1'b0;
    bus.we = 1'b0;
    #1;
    chk("sat_still_full", {31'd0, bus.iss_ready}, 32'd0);
    bus.we = 1'b1;
    repeat (3) step();
    idle();
    #1;
    chk("sat_drained", {31'd0, bus.hazard[1]}, 32'd0);
    step();

    // Protocol error: retire with nothing outstanding must not wrap.
    bus.we = 1'b1; bus.wa = 5'd9; bus.wb_clr = 1'b1;
    step();
    idle();
    #1;
    chk("no_wrap", {31'd0, bus.hazard[1]}, 32'd0);
    step();

    // Asynchronous reset mid-run.
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h1234;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd5;
    step();
    idle();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd5;
    set_ra(0, 5'd5);
    step();
    idle();
    bus.iss_addr = 5'd5;
    #1;
    chk("pre_reset_rd", bus.rd[0 +: DATA_W], 32'h1234);
    chk("pre_reset_hazard", {31'd0, bus.hazard[0]}, 32'd1);
    reset = 1'b0;
    model_clear();
    #1;
    chk("reset_rd", bus.rd[0 +: DATA_W], 32'h0);
    chk("reset_hazard", {31'd0, bus.hazard[0]}, 32'd0);
    chk("reset_ready", {31'd0, bus.iss_ready}, 32'd1);
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h5555; bus.iss_valid = 1'b1;
    step();
    idle();
    reset = 1'b1;
    #1;
    chk("reset_ignored_write", bus.rd[0 +: DATA_W], 32'h0);
    step();

    // Random traffic over a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      bus.we        = ($urandom_range(0, 1) == 1);
      bus.wa        = ADDR_W'($urandom_range(0, 7));
      bus.wd        = $urandom;
      bus.wpc       = $urandom;
      bus.wb_clr    = ($urandom_range(0, 2) != 0);
      bus.iss_valid = ($urandom_range(0, 1) == 1);
      bus.iss_addr  = ADDR_W'($urandom_range(0, 7));
      set_ra(0, ADDR_W'($urandom_range(0, 7)));
      set_ra(1, ADDR_W'($urandom_range(0, 7)));
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_sb.md
# grf_sb

Parametrised general register file with integrated pending-write scoreboard for the pipelined core. It provides NR combinational read ports with same-cycle write bypass and one synchronous write port. A per-register pending-write counter is raised at issue and lowered at writeback, and drives per-port hazard flags for the stall unit. It sits in the decode stage and replaces the fixed 2-read GRF.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NR, 2, number of read ports (1..4)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- wpc  in  32  PC of the writing instruction (trace only)
- wb_clr  in  1  this write retires a scoreboarded producer; decrement pend[wa]
- ra  in  NR*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd  out  NR*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- hazard  out  NR  port k source still has an outstanding producer
- iss_valid  in  1  issue of a producer targeting iss_addr
- iss_addr  in  ADDR_W  destination of the issuing producer
- iss_ready  out  1  pend[iss_addr] can accept another increment

## Operation
- Register 0 reads 0 always; writes, issues and clears to address 0 are ignored; pend[0] stays 0.
- Write: at a rising edge with we=1 and wa!=0, the value is stored as reg[wa] <= wd.
- Read port k: if we=1 and wa==ra_k and wa!=0, rd_k = wd (bypass). Otherwise rd_k = reg[ra_k]. The path is purely combinational.
- Each register has a 2-bit counter pend[a] (0..3).
  - inc = iss_valid && iss_ready && iss_addr==a && a!=0
  - dec = we && wb_clr && wa==a && a!=0
  - inc only: +1. dec only: -1. Both or neither: unchanged.
- iss_ready = (pend[iss_addr] != 3) || (dec on iss_addr this cycle). Issue when iss_ready=0 is dropped; the upstream stage must hold.
- dec when pend==0 is a protocol error. The counter stays at 0 and does not wrap.
- hazard_k = (ra_k!=0) && (pend[ra_k] - dec_on_ra_k) != 0. The writeback of the last outstanding producer in the same cycle clears the hazard, and the bypass supplies the data.
- An issue in the current cycle does not affect hazard in the same cycle.

## Timing
- Read and hazard latency is 0 cycles (combinational from ra, we, wa, wd, wb_clr).
- Write and counter update latency is 1 edge.
- Reset: all reg = 0, all pend = 0 asynchronously.
  - Outputs during reset: rd follows the bypass or the zeroed array; hazard = 0; iss_ready = 1.
  - Writes and issues are ignored while reset=0.
- Reset release mid-operation: there is no recovery of in-flight producers. The pipeline must flush alongside.
- Simultaneous we and iss_valid to the same address: the data write happens, and the counter nets per the inc/dec rule.

## Configuration
- GRF_WRITE_TRACE_EN defined: every effective write prints "<time>@<wpc hex>: $<wa dec> <= <wd hex>" via $display at the write edge. Writes to $0 are not printed.
- Not defined: there is no trace. wpc is unused, and synthesis removes it.

## Structure
- Package grf_pkg holds:
  - CNT_W = 2 and CNT_MAX = 3
  - the grf_cnt_t typedef
  - the pend-update helper function (inc, dec, cur → next)
- Sub-module grf_pend_cnt: one saturating up/down counter with async active-low reset. It is instantiated 2**ADDR_W-1 times via generate.
- The storage array and read muxes stay in the top module.

## Test plan
- Reset: assert reset=0 mid-run after writing $5=0x1234 → rd for ra=5 reads 0, hazard=0, iss_ready=1 immediately.
- Write/read/bypass: we=1, wa=3, wd=0xDEADBEEF, ra0=3 in the same cycle → rd0=0xDEADBEEF before the edge; reads 0xDEADBEEF afterwards with we=0.
- $0 protection: we=1, wa=0, wd=0xFFFFFFFF, then iss to 0 → rd(ra=0)=0, hazard=0, pend[0]=0.
- Scoreboard: issue $7 → next cycle hazard for ra=7 is 1. Write $7 with wb_clr=1, wd=0x42 → hazard=0 and rd=0x42 in that same cycle.
- Saturation: issue $9 three times → iss_ready=0. Fourth issue with dec on $9 in the same cycle → accepted, pend stays 3. Three more clears → hazard=0.
- Trace (GRF_WRITE_TRACE_EN): write $2=0x10 at wpc=0x3000 → exactly one line "…@00003000: $ 2 <= 00000010".
